mem_if_unit: RTL and testbench
==============================

Name: mem_if_unit

Overview:
- Holds the MAR and MBR registers of the COA CPU and runs the single-port memory handshake.
- Takes the program counter value and the 32-bit control word CON. Produces the MBR word used by the PC and the datapath.
- A read or write takes a variable number of cycles; the block asserts BUSY so the control unit stalls until the access completes.

Parameters:
- AW, 8, address width (MAR, PC_IN, MEM_ADDR)
- DW, 16, data width (MBR, memory data, ACC_IN)
- WAIT_MAX, 15, maximum cycles in a wait state before the access is aborted

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- CON  in  32  control word; bits used: [0] PC->MAR, [1] MBR[AW-1:0]->MAR, [3] read, [4] write, [5] ACC->MBR, [6] clear ERR
- PC_IN  in  AW  current program counter
- ACC_IN  in  DW  accumulator value for stores
- MAR_OUT  out  AW  MAR register
- MBR_OUT  out  DW  MBR register (feeds PC load path and ALU)
- MEM_REQ  out  1  access request, held until ack or abort
- MEM_WE  out  1  1 = write, valid with MEM_REQ
- MEM_ADDR  out  AW  equals MAR_OUT
- MEM_WDATA  out  DW  equals MBR_OUT
- MEM_RDATA  in  DW  read data, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion strobe from memory
- BUSY  out  1  1 whenever state != IDLE
- DONE  out  1  one-cycle pulse on successful completion
- ERR  out  1  sticky error (timeout or read+write conflict)

Behaviour:
- Reset (RST_N low, async): MAR=0, MBR=0, state=IDLE, wait counter=0, MEM_REQ=0, MEM_WE=0, DONE=0, ERR=0.
- States: IDLE, RD_WAIT, WR_WAIT. All outputs are registered or decoded from state only.
- IDLE register loads, on the clock edge:
  - CON[0] loads MAR<=PC_IN.
  - CON[1] loads MAR<=MBR[AW-1:0]; if CON[0] and CON[1] are both set, CON[1] wins.
  - CON[5] loads MBR<=ACC_IN.
- IDLE, CON[3]=1 and CON[4]=0: go to RD_WAIT next edge.
- IDLE, CON[4]=1 and CON[3]=0: go to WR_WAIT next edge.
- IDLE, CON[3] and CON[4] both set: ERR<=1, stay IDLE, no memory access.
- Address timing: the request starts the cycle after CON[3]/CON[4]. A MAR load in the same cycle as the request is therefore visible on MEM_ADDR.
- Write data timing: a same-cycle CON[5] load is likewise visible on MEM_WDATA.
- RD_WAIT: MEM_REQ=1, MEM_WE=0. On MEM_ACK: MBR<=MEM_RDATA, DONE=1 for the following cycle, return to IDLE.
- WR_WAIT: MEM_REQ=1, MEM_WE=1. On MEM_ACK: DONE=1 for the following cycle, return to IDLE. MBR is unchanged.
- Latency: minimum 2 cycles from the CON[3]/CON[4] edge to DONE (ack in the first wait cycle).
- BUSY is high during RD_WAIT and WR_WAIT only.
- While BUSY, CON bits 0/1/3/4/5 are ignored and MAR/MBR are frozen, except for the read-data capture.
- Wait counter:
  - Cleared on entry to a wait state; increments each wait cycle without ack.
  - If it reaches WAIT_MAX with no ack: abort to IDLE, MEM_REQ drops, ERR<=1, no DONE, MBR unchanged.
  - An ack in the same cycle the counter reaches WAIT_MAX counts as success.
- MEM_ACK while in IDLE is ignored.
- CON[6] clears ERR in any state. If CON[6] coincides with a new error, the error wins and ERR=1.
- RST_N asserted mid-access: immediate return to reset values. MEM_REQ drops asynchronously.

Decomposition:
- Shared package coa_pkg: CON bit index constants (CON_PC2MAR=0, CON_MBR2MAR=1, CON_MRD=3, CON_MWR=4, CON_ACC2MBR=5, CON_ERRCLR=6), alongside the existing CON_PCINC=14 and CON_PCLD=2; state encoding IDLE/RD_WAIT/WR_WAIT.
- One sub-module: mem_wait_timer. Clear/enable counter with a terminal-count flag at WAIT_MAX, same clock and reset.

Test Plan:
- Fetch, zero-wait: PC_IN=0x2A, CON[0] then CON[3]; memory acks the first wait cycle with 0x1234 -> MEM_ADDR=0x2A, MBR_OUT=0x1234, DONE pulses 2 cycles after the CON[3] edge, BUSY high exactly 1 cycle.
- Store, 3 wait cycles: ACC_IN=0xBEEF with CON[5]+CON[4] in the same cycle; ack after 3 cycles -> MEM_WE=1, MEM_WDATA=0xBEEF throughout, BUSY high 3 cycles, DONE once, MBR stays 0xBEEF.
- Timeout: read with no ack -> abort after WAIT_MAX=15 wait cycles, ERR=1, no DONE, MBR unchanged. CON[6] afterwards -> ERR=0.
- Conflict and priority: CON[3]+CON[4] together -> ERR=1, MEM_REQ never asserts. CON[0]+CON[1] with MBR=0x00C7, PC_IN=0x10 -> MAR=0xC7.
- Frozen while busy: during RD_WAIT pulse CON[0] with PC_IN=0x55 -> MAR unchanged. Stray MEM_ACK in IDLE -> no state change.
- Reset mid-read: deassert RST_N in RD_WAIT -> MEM_REQ=0 immediately, MAR=MBR=0, state IDLE, DONE=0.

Source files
------------

// File: rtl/coa_pkg.sv
// Shared COA CPU definitions: control-word bit positions and the memory
// interface state encoding.
package coa_pkg;

    localparam int CON_W       = 32;
    localparam int CON_PC2MAR  = 0;
    localparam int CON_MBR2MAR = 1;
    localparam int CON_PCLD    = 2;
    localparam int CON_MRD     = 3;
    localparam int CON_MWR     = 4;
    localparam int CON_ACC2MBR = 5;
    localparam int CON_ERRCLR  = 6;
    localparam int CON_PCINC   = 14;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t ST_IDLE    = 2'd0;
    localparam mem_state_t ST_RD_WAIT = 2'd1;
    localparam mem_state_t ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the memory handshake: synchronous clear, count enable,
// and a terminal flag in the wait cycle that would bring the count to WAIT_MAX.
module mem_wait_timer
    import coa_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_if_unit.sv
// COA CPU memory interface: MAR/MBR registers and the single-port request/ack
// handshake with wait-state timeout and sticky error reporting.
module mem_if_unit
    import coa_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CON_W-1:0] CON,
    input  logic [AW-1:0]    PC_IN,
    input  logic [DW-1:0]    ACC_IN,
    output logic [AW-1:0]    MAR_OUT,
    output logic [DW-1:0]    MBR_OUT,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic [AW-1:0]    MEM_ADDR,
    output logic [DW-1:0]    MEM_WDATA,
    input  logic [DW-1:0]    MEM_RDATA,
    input  logic             MEM_ACK,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [DW-1:0] mbr_q, mbr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy;
    logic          timeout;
    logic          unused_con;

    assign busy       = (state_q != ST_IDLE);
    assign unused_con = ^{CON[CON_W-1:CON_ERRCLR+1], CON[CON_PCLD]};

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk_i  (CLK),
        .rst_n_i(RST_N),
        .clr_i  (!busy),
        .en_i   (busy && !MEM_ACK),
        .tc_o   (timeout)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // Clear first so a new error raised below in the same cycle takes priority.
        if (CON[CON_ERRCLR]) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (CON[CON_MBR2MAR]) begin
                    mar_d = mbr_q[AW-1:0];
                end else if (CON[CON_PC2MAR]) begin
                    mar_d = PC_IN;
                end
                if (CON[CON_ACC2MBR]) begin
                    mbr_d = ACC_IN;
                end
                if (CON[CON_MRD] && CON[CON_MWR]) begin
                    err_d = 1'b1;
                end else if (CON[CON_MRD]) begin
                    state_d = ST_RD_WAIT;
                end else if (CON[CON_MWR]) begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (MEM_ACK) begin
                    if (state_q == ST_RD_WAIT) begin
                        mbr_d = MEM_RDATA;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            mbr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign MAR_OUT   = mar_q;
    assign MBR_OUT   = mbr_q;
    assign MEM_ADDR  = mar_q;
    assign MEM_WDATA = mbr_q;
    assign MEM_REQ   = busy;
    assign MEM_WE    = (state_q == ST_WR_WAIT);
    assign BUSY      = busy;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_mem_if_unit.sv
// Self-checking bench for mem_if_unit: scenario tasks plus a scoreboard that
// checks MAR/MBR whenever DONE pulses.
module tb_mem_if_unit;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int WAIT_MAX = 15;

    localparam int B_PC2MAR  = 0;
    localparam int B_MBR2MAR = 1;
    localparam int B_MRD     = 3;
    localparam int B_MWR     = 4;
    localparam int B_ACC2MBR = 5;
    localparam int B_ERRCLR  = 6;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [31:0]   CON = '0;
    logic [AW-1:0] PC_IN = '0;
    logic [DW-1:0] ACC_IN = '0;
    logic [AW-1:0] MAR_OUT;
    logic [DW-1:0] MBR_OUT;
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA = '0;
    logic          MEM_ACK = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    typedef struct {
        logic [AW-1:0] mar;
        logic [DW-1:0] mbr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    mem_if_unit #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CON      (CON),
        .PC_IN    (PC_IN),
        .ACC_IN   (ACC_IN),
        .MAR_OUT  (MAR_OUT),
        .MBR_OUT  (MBR_OUT),
        .MEM_REQ  (MEM_REQ),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA),
        .MEM_ACK  (MEM_ACK),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every DONE pulse must match the oldest outstanding access.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && DONE === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done got=DONE exp=no_done t=%0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (MBR_OUT !== mon_e.mbr || MAR_OUT !== mon_e.mar) begin
                    failures++;
                    $display("FAIL sb_done_regs got=mar:%h/mbr:%h exp=mar:%h/mbr:%h", MAR_OUT, MBR_OUT, mon_e.mar, mon_e.mbr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #1;
        checks++; if (MAR_OUT !== 8'h00) begin failures++; $display("FAIL rst_mar got=%h exp=00", MAR_OUT); end
        checks++; if (MBR_OUT !== 16'h0000) begin failures++; $display("FAIL rst_mbr got=%h exp=0000", MBR_OUT); end
        checks++; if ({MEM_REQ, MEM_WE, BUSY, DONE, ERR} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {MEM_REQ, MEM_WE, BUSY, DONE, ERR}); end
        cycle();
        cycle();
        RST_N = 1'b1;
        cycle();
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_fetch();
        PC_IN = 8'h2A;
        CON = 32'h1 << B_PC2MAR;
        cycle();
        CON = 32'h1 << B_MRD;
        cycle();
        checks++; if ({BUSY, MEM_REQ, MEM_WE} !== 3'b110) begin failures++; $display("FAIL fetch_req got=%b exp=110", {BUSY, MEM_REQ, MEM_WE}); end
        checks++; if (MEM_ADDR !== 8'h2A) begin failures++; $display("FAIL fetch_addr got=%h exp=2a", MEM_ADDR); end
        sb_q.push_back('{mar: 8'h2A, mbr: 16'h1234});
        CON = '0;
        MEM_ACK = 1'b1;
        MEM_RDATA = 16'h1234;
        cycle();
        MEM_ACK = 1'b0;
        checks++; if ({DONE, BUSY} !== 2'b10) begin failures++; $display("FAIL fetch_done got=%b exp=10", {DONE, BUSY}); end
        checks++; if (MBR_OUT !== 16'h1234) begin failures++; $display("FAIL fetch_mbr got=%h exp=1234", MBR_OUT); end
        cycle();
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL fetch_done_pulse got=%b exp=0", DONE); end
    endtask

    task automatic test_store();
        ACC_IN = 16'hBEEF;
        CON = (32'h1 << B_ACC2MBR) | (32'h1 << B_MWR);
        cycle();
        CON = '0;
        sb_q.push_back('{mar: 8'h2A, mbr: 16'hBEEF});
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({BUSY, MEM_REQ, MEM_WE} !== 3'b111 || MEM_WDATA !== 16'hBEEF) begin
                failures++;
                $display("FAIL store_wait%0d got=%b/%h exp=111/beef", i, {BUSY, MEM_REQ, MEM_WE}, MEM_WDATA);
            end
            MEM_ACK = (i == 2);
            cycle();
        end
        MEM_ACK = 1'b0;
        checks++; if ({DONE, BUSY, MEM_WE} !== 3'b100) begin failures++; $display("FAIL store_done got=%b exp=100", {DONE, BUSY, MEM_WE}); end
        cycle();
        checks++; if (DONE !== 1'b0 || MBR_OUT !== 16'hBEEF) begin failures++; $display("FAIL store_after got=%b/%h exp=0/beef", DONE, MBR_OUT); end
    endtask

    task automatic test_timeout();
        int n;
        CON = 32'h1 << B_MRD;
        cycle();
        CON = '0;
        n = 0;
        while (BUSY === 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        checks++; if (n != WAIT_MAX) begin failures++; $display("FAIL timeout_wait_cycles got=%0d exp=%0d", n, WAIT_MAX); end
        checks++; if ({ERR, DONE, MEM_REQ} !== 3'b100) begin failures++; $display("FAIL timeout_flags got=%b exp=100", {ERR, DONE, MEM_REQ}); end
        checks++; if (MBR_OUT !== 16'hBEEF) begin failures++; $display("FAIL timeout_mbr got=%h exp=beef", MBR_OUT); end
        CON = 32'h1 << B_ERRCLR;
        cycle();
        CON = '0;
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL timeout_errclr got=%b exp=0", ERR); end
    endtask

    task automatic test_ack_at_limit();
        CON = 32'h1 << B_MRD;
        cycle();
        CON = '0;
        sb_q.push_back('{mar: 8'h2A, mbr: 16'h5A5A});
        MEM_RDATA = 16'h5A5A;
        for (int i = 0; i < WAIT_MAX; i++) begin
            checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL limit_busy%0d got=%b exp=1", i, BUSY); end
            MEM_ACK = (i == WAIT_MAX - 1);
            cycle();
        end
        MEM_ACK = 1'b0;
        checks++; if ({DONE, ERR, BUSY} !== 3'b100) begin failures++; $display("FAIL limit_done got=%b exp=100", {DONE, ERR, BUSY}); end
        cycle();
    endtask

    task automatic test_conflict_priority();
        CON = (32'h1 << B_MRD) | (32'h1 << B_MWR);
        cycle();
        checks++; if ({ERR, MEM_REQ, BUSY} !== 3'b100) begin failures++; $display("FAIL conflict_err got=%b exp=100", {ERR, MEM_REQ, BUSY}); end
        CON = '0;
        cycle();
        checks++; if ({MEM_REQ, BUSY} !== 2'b00) begin failures++; $display("FAIL conflict_noreq got=%b exp=00", {MEM_REQ, BUSY}); end
        CON = (32'h1 << B_MRD) | (32'h1 << B_MWR) | (32'h1 << B_ERRCLR);
        cycle();
        checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL conflict_beats_clr got=%b exp=1", ERR); end
        CON = 32'h1 << B_ERRCLR;
        cycle();
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL conflict_clr got=%b exp=0", ERR); end
        ACC_IN = 16'h00C7;
        CON = 32'h1 << B_ACC2MBR;
        cycle();
        PC_IN = 8'h10;
        CON = (32'h1 << B_PC2MAR) | (32'h1 << B_MBR2MAR);
        cycle();
        CON = '0;
        checks++; if (MAR_OUT !== 8'hC7) begin failures++; $display("FAIL mar_priority got=%h exp=c7", MAR_OUT); end
    endtask

    task automatic test_frozen();
        PC_IN = 8'h55;
        CON = 32'h1 << B_MRD;
        cycle();
        ACC_IN = 16'hFFFF;
        CON = (32'h1 << B_PC2MAR) | (32'h1 << B_MBR2MAR) | (32'h1 << B_ACC2MBR) | (32'h1 << B_MRD) | (32'h1 << B_MWR);
        cycle();
        CON = '0;
        checks++; if (MAR_OUT !== 8'hC7 || MEM_ADDR !== 8'hC7) begin failures++; $display("FAIL frozen_mar got=%h exp=c7", MAR_OUT); end
        checks++; if (MBR_OUT !== 16'h00C7) begin failures++; $display("FAIL frozen_mbr got=%h exp=00c7", MBR_OUT); end
        checks++; if ({BUSY, ERR, MEM_WE} !== 3'b100) begin failures++; $display("FAIL frozen_state got=%b exp=100", {BUSY, ERR, MEM_WE}); end
        sb_q.push_back('{mar: 8'hC7, mbr: 16'h0A0B});
        MEM_ACK = 1'b1;
        MEM_RDATA = 16'h0A0B;
        cycle();
        MEM_ACK = 1'b0;
        checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL frozen_done got=%b exp=1", DONE); end
        cycle();
        MEM_ACK = 1'b1;
        MEM_RDATA = 16'hDEAD;
        cycle();
        MEM_ACK = 1'b0;
        checks++; if ({BUSY, DONE, MEM_REQ} !== 3'b000 || MBR_OUT !== 16'h0A0B) begin failures++; $display("FAIL stray_ack got=%b/%h exp=000/0a0b", {BUSY, DONE, MEM_REQ}, MBR_OUT); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] pc;
        logic [DW-1:0] acc, rdata;
        logic          rd;
        int            dly;
        for (int k = 0; k < 6; k++) begin
            rd    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pc    = AW'($urandom_range(0, 255));
            acc   = DW'($urandom_range(0, 65535));
            rdata = DW'($urandom_range(0, 65535));
            dly   = (k == 0) ? 0 : $urandom_range(0, 4);
            PC_IN  = pc;
            ACC_IN = acc;
            CON = (32'h1 << B_PC2MAR) | (rd ? (32'h1 << B_MRD) : ((32'h1 << B_MWR) | (32'h1 << B_ACC2MBR)));
            sb_q.push_back('{mar: pc, mbr: (rd ? rdata : acc)});
            cycle();
            CON = '0;
            for (int i = 0; i <= dly; i++) begin
                checks++;
                if (BUSY !== 1'b1 || MEM_ADDR !== pc || MEM_WE !== !rd || (!rd && MEM_WDATA !== acc)) begin
                    failures++;
                    $display("FAIL b2b%0d_wait%0d got=%b/%h/%b/%h exp=1/%h/%b/%h", k, i, BUSY, MEM_ADDR, MEM_WE, MEM_WDATA, pc, !rd, acc);
                end
                MEM_ACK = (i == dly);
                MEM_RDATA = rdata;
                cycle();
            end
            MEM_ACK = 1'b0;
            checks++; if ({DONE, BUSY} !== 2'b10) begin failures++; $display("FAIL b2b%0d_done got=%b exp=10", k, {DONE, BUSY}); end
        end
        cycle();
    endtask

    task automatic test_reset_mid_read();
        CON = (32'h1 << B_MRD) | (32'h1 << B_MWR);
        cycle();
        PC_IN = 8'h77;
        CON = 32'h1 << B_PC2MAR;
        cycle();
        ACC_IN = 16'h1111;
        CON = (32'h1 << B_MRD) | (32'h1 << B_ACC2MBR);
        cycle();
        CON = '0;
        checks++; if ({MEM_REQ, ERR} !== 2'b11 || MAR_OUT !== 8'h77) begin failures++; $display("FAIL midrst_pre got=%b/%h exp=11/77", {MEM_REQ, ERR}, MAR_OUT); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if ({MEM_REQ, BUSY, DONE, ERR, MEM_WE} !== 5'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=00000", {MEM_REQ, BUSY, DONE, ERR, MEM_WE}); end
        checks++; if (MAR_OUT !== 8'h00 || MBR_OUT !== 16'h0000) begin failures++; $display("FAIL midrst_regs got=%h/%h exp=00/0000", MAR_OUT, MBR_OUT); end
        @(negedge CLK);
        RST_N = 1'b1;
        cycle();
        checks++; if ({MEM_REQ, BUSY, DONE} !== 3'b000) begin failures++; $display("FAIL midrst_after got=%b exp=000", {MEM_REQ, BUSY, DONE}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_timeout();
        test_ack_at_limit();
        test_conflict_priority();
        test_frozen();
        test_back_to_back();
        test_reset_mid_read();
        cycle();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
